mem_stage: RTL
==============

# mem_stage

Pipeline memory-access stage directly downstream of the execute stage. It consumes the ALU result (address or pass-through value) plus store data and control, and performs word loads/stores over a req/ack data-memory port. It stalls upstream while an access is outstanding and presents a registered MEM/WB result to write-back.

## Interface
- `ADDR_W`, 32: data-memory address width; `alu_result[ADDR_W-1:0]` is the address.
- `TIMEOUT`, 16: maximum cycles to wait for `mem_ack` before aborting; must be ≥ 1.
- `clk`  in  1  rising-edge clock.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  execute stage presents an instruction this cycle.
- `alu_result`  in  32  ALU result: memory address for loads/stores, write-back value otherwise.
- `store_data`  in  32  register value to store.
- `mem_read`, `mem_write`  in  1 each  load / store; both high is illegal and treated as a load.
- `reg_write`  in  1  instruction writes a register.
- `rd`  in  5  destination register.
- `stall`  out  1  upstream must hold its inputs; `in_valid` is ignored while high.
- `mem_req`  out  1  memory request, held until acknowledged.
- `mem_we`  out  1  request is a store.
- `mem_addr`  out  ADDR_W  word-aligned address.
- `mem_wdata`  out  32  store data.
- `mem_ack`  in  1  memory completes the request at this edge.
- `mem_rdata`  in  32  load data, valid when `mem_ack`=1.
- `wb_valid`  out  1  write-back outputs are valid for one cycle.
- `wb_data`  out  32  load data or pass-through ALU result.
- `wb_rd`  out  5  destination register.
- `wb_reg_write`  out  1  write-back must write `wb_rd`.
- `exc_misaligned`  out  1  one-cycle pulse, aligned with `wb_valid`.
- `exc_timeout`  out  1  one-cycle pulse, aligned with `wb_valid`.

## Operation
- The FSM has two states, IDLE and BUSY. An instruction is accepted when `in_valid` is high and `stall` is low.
- Non-memory instruction in IDLE: no state change. The next cycle has `wb_valid`=1, `wb_data`=`alu_result`, and `wb_rd`/`wb_reg_write` pass through.
- Misaligned memory instruction (`alu_result[1:0]`≠0) in IDLE:
  - No memory request is issued.
  - The next cycle has `wb_valid`=1, `wb_reg_write`=0, `wb_data`=`alu_result`, `exc_misaligned`=1.
- Aligned memory instruction in IDLE:
  - At the accepting edge, register the address (`alu_result` with bits [1:0] forced 0), store data, `mem_we`, `rd` and `reg_write`.
  - Go to BUSY with `mem_req`=1. Clear the watchdog counter.
- BUSY:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable.
  - The watchdog increments each cycle that `mem_ack`=0.
  - On an edge where `mem_ack`=1, return to IDLE and drop `mem_req`. The next cycle has `wb_valid`=1.
  - For a load, `wb_data` is the captured `mem_rdata`. For a store, `wb_reg_write`=0 and `wb_data`=0.
  - If the counter reaches `TIMEOUT`-1 with `mem_ack` still 0, abort: return to IDLE, drop `mem_req`, and the next cycle has `wb_valid`=1, `wb_reg_write`=0, `exc_timeout`=1.
  - An `mem_ack` arriving together with the timeout edge takes priority: it completes normally.
- `stall` = (state==BUSY), combinational, and it is high in the ack cycle too. The next instruction is accepted no earlier than the cycle after the completing edge.
- `mem_ack` seen in IDLE is ignored.

## Timing
- Reset, asynchronous and immediate: state=IDLE, and every output is 0 (`stall`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `wb_*`, `exc_*`).
- A reset while BUSY drops `mem_req` immediately and discards the access, with no write-back.
- Latency, non-memory or misaligned: 1 cycle from the accepting edge to `wb_valid`.
- Latency, memory access: `wb_valid` appears 1 cycle after the `mem_ack` edge. The minimum is 2 cycles after acceptance, when ack comes in the first BUSY cycle.
- `wb_*` are registered and valid for exactly one cycle. `wb_rd` and `wb_data` keep their previous values when `wb_valid`=0.
- Back-to-back non-memory instructions give one `wb_valid` per cycle, with no bubbles.
- Width rules: the watchdog is `$clog2(TIMEOUT)+1` bits and saturates. The address is zero-extended or truncated to `ADDR_W`.

## Structure
- Shared package `mem_pkg` holds:
  - the state enum (`MEM_IDLE`, `MEM_BUSY`);
  - constant `WORD_BYTES`=4;
  - a packed struct `mem_wb_t` {`valid`, `data`, `rd`, `reg_write`, `exc_misaligned`, `exc_timeout`} reused by the write-back stage.
- No sub-module. The FSM, watchdog and MEM/WB register sit in one module; the MEM/WB register is held as one `mem_wb_t`.

## Test plan
- ALU pass-through: `alu_result`=0x0000_1234, `rd`=5, `reg_write`=1 for 1 cycle → next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_rd`=5, `mem_req` stays 0, `stall` stays 0.
- Load, ack after 3 BUSY cycles (address 0x100, `mem_rdata`=0xDEAD_BEEF):
  - `mem_req`=1 and `stall`=1 for 3 cycles, with `mem_addr`=0x100 stable.
  - `wb_data`=0xDEAD_BEEF and `wb_reg_write`=1 one cycle after the ack.
- Store, ack immediately (address 0x204, data 0xA5A5_A5A5): `mem_we`=1 and `mem_wdata`=0xA5A5_A5A5 → `wb_valid`=1, `wb_reg_write`=0, 2 cycles after acceptance.
- Misaligned load at 0x102: no `mem_req` → next cycle `wb_valid`=1, `exc_misaligned`=1, `wb_reg_write`=0.
- Timeout with `TIMEOUT`=4, ack never arrives → `mem_req` high for exactly 4 cycles, then `exc_timeout`=1 with `wb_valid`=1. A following ALU op completes normally.
- Reset mid-access: `rst_b`=0 asserted while BUSY → `mem_req` and `stall` drop immediately with no `wb_valid`. After release, a load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage and its write-back consumer.
package mem_pkg;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        exc_misaligned;
        logic        exc_timeout;
    } mem_wb_t;

    function automatic logic word_misaligned(input logic [31:0] addr);
        return (addr & (32'(WORD_BYTES) - 32'd1)) != 32'd0;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(32'(WORD_BYTES) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Pipeline memory stage: word loads/stores over a req/ack port with a watchdog,
// upstream stall while busy, and a registered MEM/WB result.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              in_valid,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic [4:0]        rd,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              exc_misaligned,
    output logic              exc_timeout
);

    localparam int             CW      = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  WD_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0]  WD_ONE  = {{(CW-1){1'b0}}, 1'b1};

    mem_state_e        state_r;
    logic [CW-1:0]     wd_cnt_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [4:0]        pend_rd_r;
    logic              pend_rw_r;
    mem_wb_t           wb_r;

    logic              is_mem_s;
    logic              is_store_s;
    logic              misaligned_s;
    logic [ADDR_W-1:0] aligned_addr_s;

    // Decode the incoming instruction; a load+store request is treated as a load.
    always_comb begin
        is_mem_s       = mem_read | mem_write;
        is_store_s     = mem_write & ~mem_read;
        misaligned_s   = word_misaligned(alu_result);
        aligned_addr_s = ADDR_W'(word_align(alu_result));
    end

    // FSM, watchdog, memory port registers and MEM/WB register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r     <= MEM_IDLE;
            wd_cnt_r    <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
            pend_rd_r   <= 5'd0;
            pend_rw_r   <= 1'b0;
            wb_r        <= '0;
        end else begin
            // wb_data and wb_rd deliberately hold between results
            wb_r.valid          <= 1'b0;
            wb_r.reg_write      <= 1'b0;
            wb_r.exc_misaligned <= 1'b0;
            wb_r.exc_timeout    <= 1'b0;
            case (state_r)
                MEM_IDLE: begin
                    if (in_valid && !is_mem_s) begin
                        wb_r.valid     <= 1'b1;
                        wb_r.data      <= alu_result;
                        wb_r.rd        <= rd;
                        wb_r.reg_write <= reg_write;
                    end else if (in_valid && misaligned_s) begin
                        wb_r.valid          <= 1'b1;
                        wb_r.data           <= alu_result;
                        wb_r.rd             <= rd;
                        wb_r.exc_misaligned <= 1'b1;
                    end else if (in_valid) begin
                        state_r     <= MEM_BUSY;
                        wd_cnt_r    <= '0;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= is_store_s;
                        mem_addr_r  <= aligned_addr_s;
                        mem_wdata_r <= store_data;
                        pend_rd_r   <= rd;
                        pend_rw_r   <= reg_write & ~is_store_s;
                    end else begin
                        state_r <= MEM_IDLE;
                    end
                end
                MEM_BUSY: begin
                    if (mem_ack) begin
                        state_r        <= MEM_IDLE;
                        mem_req_r      <= 1'b0;
                        mem_we_r       <= 1'b0;
                        wb_r.valid     <= 1'b1;
                        wb_r.data      <= mem_we_r ? 32'd0 : mem_rdata;
                        wb_r.rd        <= pend_rd_r;
                        wb_r.reg_write <= pend_rw_r;
                    end else if (wd_cnt_r >= WD_LAST) begin
                        state_r          <= MEM_IDLE;
                        mem_req_r        <= 1'b0;
                        mem_we_r         <= 1'b0;
                        wb_r.valid       <= 1'b1;
                        wb_r.data        <= 32'd0;
                        wb_r.rd          <= pend_rd_r;
                        wb_r.exc_timeout <= 1'b1;
                    end else if (wd_cnt_r != WD_MAX) begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
                    end else begin
                        wd_cnt_r <= wd_cnt_r;
                    end
                end
                default: begin
                    state_r   <= MEM_IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign stall          = (state_r == MEM_BUSY);
    assign mem_req        = mem_req_r;
    assign mem_we         = mem_we_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;
    assign wb_valid       = wb_r.valid;
    assign wb_data        = wb_r.data;
    assign wb_rd          = wb_r.rd;
    assign wb_reg_write   = wb_r.reg_write;
    assign exc_misaligned = wb_r.exc_misaligned;
    assign exc_timeout    = wb_r.exc_timeout;

endmodule
